// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift window, raster-order input.
// Optional per-frame window counter port (winCount) is enabled by defining CONV_WIN_COUNT_EN.
module conv_window_gen #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [DATA_W-1:0]     pixIn,
  input  logic                  pixValid,
  input  logic                  pixSof,
  output logic                  pixReady,
  output logic [9*DATA_W-1:0]   winOut,
  output logic                  winValid,
  input  logic                  winReady,
  output logic                  frameDone
`ifdef CONV_WIN_COUNT_EN
  ,
  output logic [15:0]           winCount
`endif
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned WIN_W = 9 * DATA_W;

  logic [COL_W-1:0]  col_q, col_d, cur_col;
  logic [ROW_W-1:0]  row_q, row_d, cur_row;
  logic [WIN_W-1:0]  win_q, win_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] lb1_mem [IMG_W];
  logic [DATA_W-1:0] lb2_mem [IMG_W];
  logic [DATA_W-1:0] lb1_rd, lb2_rd;
  logic              accept, last_col, last_row, emit;

  assign pixReady  = ~valid_q | winReady;
  assign accept    = pixValid & pixReady;
  assign winOut    = win_q;
  assign winValid  = valid_q;
  assign frameDone = done_q;

  // Position of the pixel offered this cycle; a start-of-frame forces (0,0).
  always_comb begin
    cur_col  = pixSof ? '0 : col_q;
    cur_row  = pixSof ? '0 : row_q;
    last_col = (cur_col == COL_W'(IMG_W - 1));
    last_row = (cur_row == ROW_W'(IMG_H - 1));
    emit     = accept & (cur_row >= ROW_W'(2)) & (cur_col >= COL_W'(2));
    lb1_rd   = lb1_mem[cur_col];
    lb2_rd   = lb2_mem[cur_col];
  end

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    if (accept) begin
      col_d  = last_col ? '0 : cur_col + COL_W'(1);
      row_d  = last_col ? (last_row ? '0 : cur_row + ROW_W'(1)) : cur_row;
      done_d = last_col & last_row;
      for (int r = 0; r < 3; r++) begin
        win_d[DATA_W*(3*r)   +: DATA_W] = win_q[DATA_W*(3*r+1) +: DATA_W];
        win_d[DATA_W*(3*r+1) +: DATA_W] = win_q[DATA_W*(3*r+2) +: DATA_W];
      end
      win_d[DATA_W*2 +: DATA_W] = lb2_rd;
      win_d[DATA_W*5 +: DATA_W] = lb1_rd;
      win_d[DATA_W*8 +: DATA_W] = pixIn;
    end
    // A new window replaces a handed-off one in the same cycle without a gap.
    if (emit) begin
      valid_d = 1'b1;
    end else if (winReady) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Line buffers hold no reset state; emission never reaches rows not yet rewritten.
  always_ff @(posedge Clk) begin
    if (accept) begin
      lb2_mem[cur_col] <= lb1_rd;
      lb1_mem[cur_col] <= pixIn;
    end
  end

`ifdef CONV_WIN_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Saturating handshake counter; an accepted start-of-frame clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (valid_q & winReady & (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
    if (accept & pixSof) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign winCount = cnt_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: frame-level reference model with per-cycle compare plus literal pins.
// Define CONV_WIN_COUNT_EN to also exercise the winCount port.
module tb_conv_window_gen;

  localparam int unsigned DW = 16;
  localparam int unsigned W  = 8;
  localparam int unsigned H  = 8;

  logic              Clk;
  logic              Rst;
  logic [DW-1:0]     pixIn;
  logic              pixValid;
  logic              pixSof;
  logic              pixReady;
  logic [9*DW-1:0]   winOut;
  logic              winValid;
  logic              winReady;
  logic              frameDone;
`ifdef CONV_WIN_COUNT_EN
  logic [15:0]       winCount;
`endif

  conv_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .pixIn    (pixIn),
    .pixValid (pixValid),
    .pixSof   (pixSof),
    .pixReady (pixReady),
    .winOut   (winOut),
    .winValid (winValid),
    .winReady (winReady),
    .frameDone(frameDone)
`ifdef CONV_WIN_COUNT_EN
    ,
    .winCount (winCount)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: the image as seen so far and the pending window.
  logic [DW-1:0]   img [H][W];
  int              pr, pc, r, c;
  bit              m_valid, m_fd, hs, acc;
  logic [9*DW-1:0] m_win, first_win, last_win;
  int              m_cnt, win_cnt, fd_cnt;
  int              rdy_mode;

  always @(posedge Clk) begin
    #2;
    case (rdy_mode)
      0:       winReady = 1'b1;
      1:       winReady = ($urandom_range(0, 9) < 7);
      default: winReady = 1'b0;
    endcase
  end

  always @(negedge Clk) begin
    if (!Rst) begin
      chk("rst_winValid", winValid, 0);
      chk("rst_pixReady", pixReady, 1);
      chk("rst_frameDone", frameDone, 0);
      chk("rst_winOut", winOut, 0);
`ifdef CONV_WIN_COUNT_EN
      chk("rst_winCount", winCount, 0);
`endif
      m_valid = 0; m_fd = 0; pr = 0; pc = 0; m_cnt = 0;
    end else begin
      chk("winValid", winValid, m_valid);
      chk("pixReady", pixReady, !m_valid || winReady);
      chk("frameDone", frameDone, m_fd);
      if (m_valid) chk("winOut", winOut, m_win);
`ifdef CONV_WIN_COUNT_EN
      chk("winCount", winCount, m_cnt);
`endif
      if (frameDone) fd_cnt++;
      hs  = m_valid && winReady;
      acc = pixValid && (!m_valid || winReady);
      if (hs) begin
        if (win_cnt == 0) first_win = winOut;
        last_win = winOut;
        win_cnt++;
        if (m_cnt < 65535) m_cnt++;
      end
      if (acc && pixSof) m_cnt = 0;
      m_fd = 0;
      if (acc) begin
        r = pixSof ? 0 : pr;
        c = pixSof ? 0 : pc;
        img[r][c] = pixIn;
        if (r >= 2 && c >= 2) begin
          m_valid = 1;
          for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++)
              m_win[DW*(3*rr+cc) +: DW] = img[r-2+rr][c-2+cc];
        end else if (winReady) begin
          m_valid = 0;
        end
        m_fd = (r == H-1) && (c == W-1);
        if (c == W-1) begin
          pc = 0;
          pr = (r == H-1) ? 0 : r + 1;
        end else begin
          pc = c + 1;
          pr = r;
        end
      end else if (winReady) begin
        m_valid = 0;
      end
    end
  end

  task automatic send_pix(input int idx, input bit sof, input int base,
                          input bit rnd_data, input bit rnd_valid);
    int waited;
    if (rnd_valid) begin
      while ($urandom_range(0, 3) == 0) begin
        pixValid = 1'b0;
        @(posedge Clk); #1;
      end
    end
    pixValid = 1'b1;
    pixSof   = sof;
    pixIn    = rnd_data ? DW'($urandom) : DW'(base + idx);
    waited   = 0;
    @(negedge Clk);
    while (!pixReady && waited < 200) begin
      @(negedge Clk);
      waited++;
    end
    if (!pixReady) chk("accept_timeout", 0, 1);
    @(posedge Clk); #1;
    pixSof = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit sof, input int base,
                            input bit rnd_data, input bit rnd_valid);
    for (int i = 0; i < n; i++) send_pix(i, sof && (i == 0), base, rnd_data, rnd_valid);
  endtask

  task automatic idle(input int n);
    pixValid = 1'b0;
    pixSof   = 1'b0;
    repeat (n) begin
      @(posedge Clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Rst = 1'b0; pixValid = 1'b0; pixSof = 1'b0; pixIn = '0; rdy_mode = 0;
    win_cnt = 0; fd_cnt = 0;
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b1;
    idle(2);

    // Ramp frame: pixel = 8*row + col
    win_cnt = 0; fd_cnt = 0;
    send_frame(64, 1, 0, 0, 0);
    idle(4);
    chk("rampA_windows", win_cnt, 36);
    chk("rampA_frameDone", fd_cnt, 1);
    chk("rampA_first", first_win,
        {16'd18, 16'd17, 16'd16, 16'd10, 16'd9, 16'd8, 16'd2, 16'd1, 16'd0});
    chk("rampA_last", last_win,
        {16'd63, 16'd62, 16'd61, 16'd55, 16'd54, 16'd53, 16'd47, 16'd46, 16'd45});
`ifdef CONV_WIN_COUNT_EN
    chk("rampA_winCount", winCount, 36);
`endif

    // Backpressure: hold winReady low for 5 cycles with a window pending
    win_cnt = 0; fd_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      send_pix(i, i == 0, 0, 0, 0);
`ifdef CONV_WIN_COUNT_EN
      if (i == 0) chk("sof_winCount_clear", winCount, 0);
`endif
    end
    pixValid = 1'b1; pixIn = DW'(20); rdy_mode = 2;
    repeat (5) begin
      @(negedge Clk);
      chk("stall_pixReady", pixReady, 0);
      chk("stall_winValid", winValid, 1);
      chk("stall_winOut", winOut,
          {16'd19, 16'd18, 16'd17, 16'd11, 16'd10, 16'd9, 16'd3, 16'd2, 16'd1});
    end
    @(posedge Clk); #1;
    rdy_mode = 0;
    for (int i = 20; i < 64; i++) send_pix(i, 0, 0, 0, 0);
    idle(4);
    chk("stall_windows", win_cnt, 36);
    chk("stall_frameDone", fd_cnt, 1);

    // Reset right after pixel 30, then a frame without pixSof
    win_cnt = 0;
    send_frame(31, 1, 200, 0, 0);
    chk("prereset_windows", win_cnt, 10);
    Rst = 1'b0;
    #1;
    chk("async_rst_winValid", winValid, 0);
    chk("async_rst_winOut", winOut, 0);
    idle(2);
    Rst = 1'b1;
    win_cnt = 0; fd_cnt = 0;
    send_frame(64, 0, 300, 0, 0);
    idle(4);
    chk("postreset_windows", win_cnt, 36);
    chk("postreset_frameDone", fd_cnt, 1);

    // pixSof reasserted after 20 pixels
    win_cnt = 0; fd_cnt = 0;
    send_frame(20, 1, 400, 0, 0);
    send_frame(64, 1, 500, 0, 0);
    idle(4);
    chk("resync_windows", win_cnt, 38);
    chk("resync_frameDone", fd_cnt, 1);

    // Back-to-back frames, no idle cycles
    win_cnt = 0; fd_cnt = 0;
    send_frame(64, 1, 1000, 0, 0);
    send_frame(64, 1, 2000, 0, 0);
    idle(4);
    chk("b2b_windows", win_cnt, 72);
    chk("b2b_frameDone", fd_cnt, 2);

    // Random data, random valid gaps and random backpressure
    repeat (4) begin
      win_cnt = 0; fd_cnt = 0; rdy_mode = 1;
      send_frame(64, 1, 0, 1, 1);
      rdy_mode = 0;
      idle(6);
      chk("rand_windows", win_cnt, 36);
      chk("rand_frameDone", fd_cnt, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
